// File: rtl/adc_packer_pkg.sv
// Shared types and widths for the ADC lock-and-pack stream block.
// Holds the control FSM states, packed output layout and lock-counter width.
package adc_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int CH_W       = 16;
    localparam int OUT_W      = 2 * CH_W;
    localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/adc_sample_fifo.sv
// Small synchronous FIFO holding packed sample words for the AXI-Stream side.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module adc_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage is cleared too so the read port shows zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_adc_lock_packer.sv
// ADC capture-to-AXI-Stream packer that trains on test patterns before streaming.
// Optional sample_cnt output is enabled by defining ADC_PACKER_SAMPLE_CNT_EN.
module axis_adc_lock_packer
    import adc_packer_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int LOCK_CYCLES    = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_in_0,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_in_1,
    input  logic                      pattern_valid_0,
    input  logic                      pattern_valid_1,
    input  logic                      cfg_enable,
    output logic [OUT_W-1:0]          m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      locked,
`ifdef ADC_PACKER_SAMPLE_CNT_EN
    output logic                      overflow,
    output logic [31:0]               sample_cnt
`else
    output logic                      overflow
`endif
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

    logic [ADC_DATA_WIDTH-1:0] r_s1_0;
    logic [ADC_DATA_WIDTH-1:0] r_s1_1;
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [LOCK_CNT_W-1:0]     r_lock_cnt;
    logic [LOCK_CNT_W-1:0]     w_lock_cnt_nxt;
    logic                      w_train_entry;
    logic                      r_overflow;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_drop;
    logic [OUT_W-1:0]          w_packed;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1_0 <= '0;
            r_s1_1 <= '0;
        end else begin
            r_s1_0 <= adc_dat_in_0;
            r_s1_1 <= adc_dat_in_1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_train_entry  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_lock_cnt_nxt = '0;
                if (cfg_enable) begin
                    w_state_nxt   = ST_TRAIN;
                    w_train_entry = 1'b1;
                end
            end
            ST_TRAIN: begin
                if (!cfg_enable) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                end else if (pattern_valid_0 && pattern_valid_1) begin
                    if (r_lock_cnt == LOCK_LAST) begin
                        w_state_nxt    = ST_RUN;
                        w_lock_cnt_nxt = '0;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                    end
                end else begin
                    w_lock_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // Pushing is gated by cfg_enable so a disable stops the stream that same cycle.
    assign w_push   = (r_state == ST_RUN) & cfg_enable;
    assign w_pop    = ~w_empty & m_axis_tready;
    assign w_drop   = w_push & w_full & ~w_pop;
    assign w_packed = {CH_W'($signed(r_s1_1)), CH_W'($signed(r_s1_0))};

    adc_sample_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_packed),
        .o_rdata (m_axis_tdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_overflow <= 1'b0;
        end else if (w_train_entry) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef ADC_PACKER_SAMPLE_CNT_EN
    logic [31:0] r_sample_cnt;
    logic        w_accept;

    assign w_accept = w_push & (~w_full | w_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sample_cnt <= '0;
        end else if (w_train_entry) begin
            r_sample_cnt <= '0;
        end else if (w_accept) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`endif

    assign m_axis_tvalid = ~w_empty;
    assign locked        = (r_state == ST_RUN);
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_adc_lock_packer.sv
// Bench for axis_adc_lock_packer: directed vectors plus random traffic
// checked against a queue-based reference model.
module tb_axis_adc_lock_packer;

    localparam int W     = 14;
    localparam int LOCK  = 16;
    localparam int DEPTH = 4;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  d0      = '0;
    logic [W-1:0]  d1      = '0;
    logic          v0      = 1'b0;
    logic          v1      = 1'b0;
    logic          en      = 1'b0;
    logic          tready  = 1'b0;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          lck;
    logic          ovf;
`ifdef ADC_PACKER_SAMPLE_CNT_EN
    logic [31:0]   scnt;
`endif

    axis_adc_lock_packer #(
        .ADC_DATA_WIDTH (W),
        .LOCK_CYCLES    (LOCK),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .adc_dat_in_0    (d0),
        .adc_dat_in_1    (d1),
        .pattern_valid_0 (v0),
        .pattern_valid_1 (v1),
        .cfg_enable      (en),
        .m_axis_tdata    (tdata),
        .m_axis_tvalid   (tvalid),
        .m_axis_tready   (tready),
        .locked          (lck),
`ifdef ADC_PACKER_SAMPLE_CNT_EN
        .overflow        (ovf),
        .sample_cnt      (scnt)
`else
        .overflow        (ovf)
`endif
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Reference model: streak of good cycles, mode flags, a queue as the FIFO.
    bit          m_train;
    bit          m_run;
    int          m_streak;
    bit          m_ovf;
    logic [31:0] m_q[$];
    logic [W-1:0] m_s0;
    logic [W-1:0] m_s1;
    int unsigned m_cnt;

    typedef struct {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [31:0]  exp;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [15:0] sx(logic [W-1:0] v);
        int s;
        s = int'(v);
        if (s >= (1 << (W - 1))) s = s - (1 << W);
        return 16'(s);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    task automatic mreset();
        m_train  = 0;
        m_run    = 0;
        m_streak = 0;
        m_ovf    = 0;
        m_q.delete();
        m_s0     = '0;
        m_s1     = '0;
        m_cnt    = 0;
    endtask

    task automatic mstep();
        bit pop;
        bit push;
        pop  = (m_q.size() > 0) && tready;
        push = m_run && en;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({sx(m_s1), sx(m_s0)});
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
        end
        if (m_run) begin
            if (!en) m_run = 0;
        end else if (m_train) begin
            if (!en) begin
                m_train = 0;
            end else if (v0 && v1) begin
                m_streak++;
                if (m_streak == LOCK) begin
                    m_train = 0;
                    m_run   = 1;
                end
            end else begin
                m_streak = 0;
            end
        end else if (en) begin
            m_train  = 1;
            m_streak = 0;
            m_ovf    = 0;
            m_cnt    = 0;
        end
        m_s0 = d0;
        m_s1 = d1;
    endtask

    task automatic tick();
        @(posedge aclk);
        if (!aresetn) mreset();
        else mstep();
        #1;
        if (aresetn) begin
            chk("m_tvalid", 32'(tvalid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) chk("m_tdata", tdata, m_q[0]);
            chk("m_locked", 32'(lck), 32'(m_run));
            chk("m_overflow", 32'(ovf), 32'(m_ovf));
`ifdef ADC_PACKER_SAMPLE_CNT_EN
            chk("m_sample_cnt", scnt, m_cnt);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{14'h2000, 14'h1FFF, 32'h1FFF_E000};
        tbl[1] = '{14'h0000, 14'h0000, 32'h0000_0000};
        tbl[2] = '{14'h3FFF, 14'h0001, 32'h0001_FFFF};
        tbl[3] = '{14'h1FFF, 14'h2000, 32'hE000_1FFF};
        tbl[4] = '{14'h0001, 14'h3FFE, 32'hFFFE_0001};
        mreset();

        #3;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_locked", 32'(lck), 32'd0);
        chk("rst_overflow", 32'(ovf), 32'd0);
        #9 aresetn = 1'b1;

        // Lock after exactly LOCK good cycles.
        en = 1; v0 = 1; v1 = 1;
        tick();
        chk("lock_idle_step", 32'(lck), 32'd0);
        repeat (LOCK - 1) tick();
        chk("lock_early", 32'(lck), 32'd0);
        tick();
        chk("lock_on", 32'(lck), 32'd1);

        // Sign-extension table, each sample two edges after presentation.
        tready = 1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                d0 = tbl[i].d0;
                d1 = tbl[i].d1;
            end
            tick();
            if (i > 0) begin
                chk("tbl_tdata", tdata, tbl[i-1].exp);
                chk("tbl_tvalid", 32'(tvalid), 32'd1);
            end
        end

        // A single bad cycle restarts the lock count.
        en = 0;
        repeat (3) tick();
        en = 1; d0 = '0; d1 = '0;
        tick();
        repeat (10) tick();
        v1 = 0;
        tick();
        v1 = 1;
        repeat (LOCK - 1) tick();
        chk("glitch_no_early", 32'(lck), 32'd0);
        tick();
        chk("glitch_lock", 32'(lck), 32'd1);

        // Overflow: first DEPTH samples kept in order.
        en = 0;
        repeat (3) tick();
        tready = 0; en = 1; d1 = '0;
        tick();
        for (int i = 0; i < LOCK; i++) begin
            d0 = W'(16 + i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            d0 = W'(32 + k);
            tick();
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_head", tdata, 32'h0000_001F);
        en = 0; tready = 1;
        tick();
        chk("ovf_e1", tdata, 32'h0000_0020);
        tick();
        chk("ovf_e2", tdata, 32'h0000_0021);
        tick();
        chk("ovf_e3", tdata, 32'h0000_0022);
        tick();
        chk("ovf_empty", 32'(tvalid), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        en = 1;
        tick();
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // Full FIFO with simultaneous pop takes the push.
        tready = 0;
        repeat (LOCK) tick();
        repeat (DEPTH) tick();
        chk("full_tvalid", 32'(tvalid), 32'd1);
        tready = 1;
        tick();
        chk("full_pop_no_ovf", 32'(ovf), 32'd0);
        repeat (3) tick();
        chk("full_pop_ovf_hold", 32'(ovf), 32'd0);

        // Reset mid-stream with three samples buffered.
        en = 0;
        repeat (6) tick();
        en = 1; tready = 0;
        tick();
        repeat (LOCK) tick();
        repeat (3) tick();
        chk("pre_rst_tvalid", 32'(tvalid), 32'd1);
        #2 aresetn = 0;
        #1;
        chk("arst_tvalid", 32'(tvalid), 32'd0);
        chk("arst_locked", 32'(lck), 32'd0);
        chk("arst_tdata", tdata, 32'd0);
        mreset();
        en = 0;
        repeat (2) tick();
        aresetn = 1;
        tick();
        chk("post_rst_locked", 32'(lck), 32'd0);
        chk("post_rst_tvalid", 32'(tvalid), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            en     = ($urandom_range(0, 199) != 0);
            v0     = ($urandom_range(0, 99) < 97);
            v1     = ($urandom_range(0, 99) < 97);
            tready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
            d0     = W'($urandom);
            d1     = W'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_adc_lock_packer.md
AXIS_ADC_LOCK_PACKER -- requirements
Module: axis_adc_lock_packer

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 14: bits per channel sample from the DDR capture stage.
REQ-002 SHALL have parameter LOCK_CYCLES, default 16: consecutive dual-channel pattern-valid cycles required to lock (range 1..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries (power of 2, 2..16).
REQ-004 SHALL have port aclk, input, 1: sole clock; all logic on the rising edge.
REQ-005 SHALL have port aresetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port adc_dat_in_0, input, ADC_DATA_WIDTH: channel 0 two's-complement sample.
REQ-007 SHALL have port adc_dat_in_1, input, ADC_DATA_WIDTH: channel 1 two's-complement sample.
REQ-008 SHALL have port pattern_valid_0, input, 1: channel 0 test-pattern check result.
REQ-009 SHALL have port pattern_valid_1, input, 1: channel 1 test-pattern check result.
REQ-010 SHALL have port cfg_enable, input, 1: software request to train and stream.
REQ-011 SHALL have port m_axis_tdata, output, 32: [15:0] ch0, [31:16] ch1, each sign-extended.
REQ-012 SHALL have port m_axis_tvalid, output, 1: AXI-Stream valid.
REQ-013 SHALL have port m_axis_tready, input, 1: AXI-Stream ready.
REQ-014 SHALL have port locked, output, 1: high while in RUN.
REQ-015 SHALL have port overflow, output, 1: sticky flag, set when a sample was dropped.

Function
REQ-016 SHALL register both data inputs every cycle (stage S1), unconditionally.
REQ-017 SHALL implement FSM states IDLE, TRAIN, RUN.
REQ-018 IDLE: cfg_enable=1 SHALL move to TRAIN next cycle; lock counter cleared.
REQ-019 TRAIN: counter increments on cycles with pattern_valid_0 & pattern_valid_1 both high; any other cycle resets it to 0.
REQ-020 TRAIN: when a both-valid cycle occurs with counter == LOCK_CYCLES-1, SHALL move to RUN on that edge; overflow cleared on TRAIN entry.
REQ-021 RUN: pattern_valid inputs SHALL be ignored; one S1 sample pushed into FIFO every cycle.
REQ-022 cfg_enable=0 in TRAIN or RUN SHALL return to IDLE next cycle; pushes stop immediately, FIFO contents drain normally (no flush).
REQ-023 Latency: sample present before edge n, first RUN push -> m_axis_tvalid/tdata valid after edge n+1 with empty FIFO (2 cycles).
REQ-024 m_axis_tvalid = FIFO not empty; pop on tvalid & tready; tdata SHALL be stable while tvalid & !tready.
REQ-025 Full FIFO with push and no pop: sample dropped, overflow set, FIFO unchanged.
REQ-026 Full FIFO with push and pop same cycle: push SHALL be accepted, no drop, no overflow.
REQ-027 Empty FIFO: pop impossible (tvalid low); pointers wrap modulo FIFO_DEPTH.
REQ-028 Sign extension: bits [15:ADC_DATA_WIDTH] of each half copy the sample MSB.

Reset
REQ-029 aresetn low SHALL immediately force: state IDLE, counter 0, FIFO empty, m_axis_tvalid 0, m_axis_tdata 0, locked 0, overflow 0, S1 registers 0.
REQ-030 Reset mid-stream SHALL discard buffered samples; after release, operation restarts from IDLE.

Configuration
REQ-031 With ADC_PACKER_SAMPLE_CNT_EN defined: extra output port sample_cnt (32) counts FIFO pushes accepted, wraps 0xFFFFFFFF->0, cleared on reset and on TRAIN entry.
REQ-032 Without ADC_PACKER_SAMPLE_CNT_EN: port and counter absent; all other behaviour identical.

Structure
REQ-033 Package adc_packer_pkg SHALL hold the FSM state enum, output width constant (16 per channel, 32 total) and lock-counter width.
REQ-034 FIFO SHALL be a sub-module adc_sample_fifo (parameters width, depth; push/pop/full/empty).

Verification
REQ-035 LOCK_CYCLES=16, cfg_enable=1, both valid 16 cycles -> locked=1 after 16th valid edge (+1 from IDLE).
REQ-036 Valid for 10 cycles, pattern_valid_1=0 one cycle, then valid 16 -> lock only after the last 16; no early lock.
REQ-037 RUN, tready=1, ch0=14'h2000, ch1=14'h1FFF -> tdata=32'h1FFF_E000 two cycles later, tvalid continuous.
REQ-038 RUN, tready=0 for 10 cycles, FIFO_DEPTH=4 -> 4 entries kept (first 4 samples, in order), overflow=1; re-TRAIN clears it.
REQ-039 Full FIFO, tready=1 same cycle as push -> no drop, overflow stays 0.
REQ-040 aresetn pulsed low in RUN with 3 buffered -> tvalid=0, locked=0 immediately; IDLE after release.
